// File: rtl/uart_rx.sv
// UART receiver with oversampled start detection, optional parity and
// single-cycle result pulses. A received word is only published on
// valid or frame_err, so data never shows a partially shifted frame.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // synchronizer and edge-detect history
  logic rx_meta_reg;
  logic rxs_reg;
  logic rxs_prev_reg;
  logic fall_edge;

  // frame state
  state_t               state_reg,      state_next;
  logic [CNT_W-1:0]     cnt_reg,        cnt_next;
  logic [IDX_W-1:0]     idx_reg,        idx_next;
  logic [DATA_BITS-1:0] shift_reg,      shift_next;
  logic                 par_bad_reg,    par_bad_next;
  logic                 edge_pend_reg,  edge_pend_next;

  // published results
  logic [DATA_BITS-1:0] data_reg,       data_next;
  logic                 valid_reg,      valid_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg,  frame_err_next;

  // Two-flop synchronizer for the asynchronous line; idles high so reset
  // never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg  <= rx;
      rxs_reg      <= rx_meta_reg;
      rxs_prev_reg <= rxs_reg;
    end
  end

  assign fall_edge = rxs_prev_reg & ~rxs_reg;

  // State register for the receive FSM and its datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      par_bad_reg    <= 1'b0;
      edge_pend_reg  <= 1'b0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      par_bad_reg    <= par_bad_next;
      edge_pend_reg  <= edge_pend_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Next-state logic: the sample counter only moves on rx_clk ticks, and
  // each bit is sampled when the counter hits its last value.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    par_bad_next    = par_bad_reg;
    edge_pend_next  = 1'b0;
    data_next       = data_reg;
    valid_next      = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // A start edge seen on the stop-sample cycle is carried over here.
        if (fall_edge || edge_pend_reg) begin
          state_next   = START;
          cnt_next     = '0;
          idx_next     = '0;
          par_bad_next = 1'b0;
        end
      end

      START: begin
        if (rx_clk) begin
          if (cnt_reg == HALF_LAST) begin
            cnt_next = '0;
            idx_next = '0;
            // line back high at mid start bit means it was only a glitch
            state_next = rxs_reg ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (rx_clk) begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next   = '0;
            shift_next = {rxs_reg, shift_reg[DATA_BITS-1:1]};
            if (idx_reg == IDX_LAST) begin
              idx_next   = '0;
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      PARITY: begin
        if (rx_clk) begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next     = '0;
            par_bad_next = ((^shift_reg) ^ rxs_reg) != PAR_ODD;
            state_next   = STOP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (rx_clk) begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next       = '0;
            state_next     = IDLE;
            data_next      = shift_reg;
            edge_pend_next = fall_edge;
            if (rxs_reg) begin
              valid_next      = 1'b1;
              parity_err_next = (PARITY_EN != 0) && par_bad_reg;
            end else begin
              frame_err_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign data       = data_reg;
  assign valid      = valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, each
// fed by its own serial line, with rx_clk ticking every 4 clk (16x).
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst_n;
  logic       rx_clk;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       busy_a, busy_b;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // monitor state, instance a
  int         vcnt_a = 0;
  int         fcnt_a = 0;
  int         pcnt_a = 0;
  int         glitch_a = 0;
  logic [7:0] last_a = 8'h00;
  logic [7:0] prev_data_a = 8'h00;
  logic       busy_after_a = 1'b1;
  logic       valid_prev_a = 1'b0;
  logic [7:0] q_a[$];

  // monitor state, instance b
  int         vcnt_b = 0;
  int         fcnt_b = 0;
  int         orphan_perr_b = 0;
  logic [7:0] last_b = 8'h00;
  logic       last_perr_b = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_clk(rx_clk), .rx(rx_a),
    .data(data_a), .valid(valid_a), .parity_err(perr_a),
    .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_clk(rx_clk), .rx(rx_b),
    .data(data_b), .valid(valid_b), .parity_err(perr_b),
    .frame_err(ferr_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud tick: one clk wide, every fourth clk
  initial begin
    int div;
    div = 0;
    rx_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      rx_clk = (div == 0);
    end
  end

  // output monitors sampled on the falling edge
  always @(negedge clk) begin
    if (valid_prev_a) busy_after_a = busy_a;
    valid_prev_a = valid_a;
    if (valid_a) begin
      vcnt_a++;
      last_a = data_a;
      q_a.push_back(data_a);
      if (perr_a) pcnt_a++;
    end
    if (ferr_a) fcnt_a++;
    if (rst_n && (data_a !== prev_data_a) && !valid_a && !ferr_a) glitch_a++;
    prev_data_a = data_a;

    if (valid_b) begin
      vcnt_b++;
      last_b = data_b;
      last_perr_b = perr_b;
    end
    if (perr_b && !valid_b) orphan_perr_b++;
    if (ferr_b) fcnt_b++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic clear_mon();
    vcnt_a = 0; fcnt_a = 0; pcnt_a = 0; q_a.delete();
    busy_after_a = 1'b1;
    vcnt_b = 0; fcnt_b = 0; orphan_perr_b = 0; last_perr_b = 1'b0;
  endtask

  // shift a frame onto one line, LSB (start bit) first
  task automatic send_bits(input bit which, input logic [15:0] bits, input int n);
    $display("tx line %0d: %0d bits, pattern %04h", which, n, bits);
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      wait_clk(BIT_CLKS);
    end
  endtask

  function automatic logic [15:0] frame_8n1(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_8p1(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    wait_clk(5);
    assert_cnt++; if (data_a !== 8'h00) begin fail_cnt++; $display("FAIL reset_data: got %h expected 00", data_a); end
    assert_cnt++; if (valid_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    assert_cnt++; if (perr_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_perr: got %b expected 0", perr_a); end
    assert_cnt++; if (ferr_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_ferr: got %b expected 0", ferr_a); end
    assert_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b%b expected 00", busy_a, busy_b); end
    rst_n = 1'b1;
    wait_clk(20);
    clear_mon();
  endtask

  task automatic test_basic();
    clear_mon();
    send_bits(1'b0, frame_8n1(8'hA5, 1'b1), 10);
    wait_clk(8);
    assert_cnt++; if (vcnt_a !== 1) begin fail_cnt++; $display("FAIL basic_valid_count: got %0d expected 1", vcnt_a); end
    assert_cnt++; if (last_a !== 8'hA5) begin fail_cnt++; $display("FAIL basic_data: got %h expected a5", last_a); end
    assert_cnt++; if (pcnt_a !== 0) begin fail_cnt++; $display("FAIL basic_perr: got %0d expected 0", pcnt_a); end
    assert_cnt++; if (fcnt_a !== 0) begin fail_cnt++; $display("FAIL basic_ferr: got %0d expected 0", fcnt_a); end
    assert_cnt++; if (busy_after_a !== 1'b0) begin fail_cnt++; $display("FAIL basic_busy_after_valid: got %b expected 0", busy_after_a); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_a = 1'b0;
    wait_clk(16);
    rx_a = 1'b1;
    assert_cnt++; if (busy_a !== 1'b1) begin fail_cnt++; $display("FAIL glitch_busy_start: got %b expected 1", busy_a); end
    wait_clk(32);
    assert_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL glitch_busy_end: got %b expected 0", busy_a); end
    wait_clk(200);
    assert_cnt++; if (vcnt_a !== 0 || fcnt_a !== 0) begin fail_cnt++; $display("FAIL glitch_no_pulse: got valid=%0d ferr=%0d expected 0 0", vcnt_a, fcnt_a); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_bits(1'b0, frame_8n1(8'h3C, 1'b0), 10);
    wait_clk(3 * BIT_CLKS - BIT_CLKS);
    assert_cnt++; if (fcnt_a !== 1) begin fail_cnt++; $display("FAIL ferr_count: got %0d expected 1", fcnt_a); end
    assert_cnt++; if (vcnt_a !== 0) begin fail_cnt++; $display("FAIL ferr_no_valid: got %0d expected 0", vcnt_a); end
    assert_cnt++; if (data_a !== 8'h3C) begin fail_cnt++; $display("FAIL ferr_data: got %h expected 3c", data_a); end
    assert_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL ferr_break_idle: got %b expected 0", busy_a); end
    rx_a = 1'b1;
    wait_clk(2 * BIT_CLKS);
    send_bits(1'b0, frame_8n1(8'h55, 1'b1), 10);
    wait_clk(8);
    assert_cnt++; if (vcnt_a !== 1 || last_a !== 8'h55) begin fail_cnt++; $display("FAIL ferr_recover: got count=%0d data=%h expected 1 55", vcnt_a, last_a); end
    assert_cnt++; if (fcnt_a !== 1) begin fail_cnt++; $display("FAIL ferr_recover_ferr: got %0d expected 1", fcnt_a); end
  endtask

  task automatic test_parity();
    clear_mon();
    send_bits(1'b1, frame_8p1(8'h07, 1'b0), 11);
    wait_clk(8);
    assert_cnt++; if (vcnt_b !== 1 || last_b !== 8'h07) begin fail_cnt++; $display("FAIL parity_bad_valid: got count=%0d data=%h expected 1 07", vcnt_b, last_b); end
    assert_cnt++; if (last_perr_b !== 1'b1) begin fail_cnt++; $display("FAIL parity_bad_flag: got %b expected 1", last_perr_b); end
    clear_mon();
    send_bits(1'b1, frame_8p1(8'h07, 1'b1), 11);
    wait_clk(8);
    assert_cnt++; if (vcnt_b !== 1 || last_b !== 8'h07) begin fail_cnt++; $display("FAIL parity_good_valid: got count=%0d data=%h expected 1 07", vcnt_b, last_b); end
    assert_cnt++; if (last_perr_b !== 1'b0) begin fail_cnt++; $display("FAIL parity_good_flag: got %b expected 0", last_perr_b); end
    assert_cnt++; if (fcnt_b !== 0 || orphan_perr_b !== 0) begin fail_cnt++; $display("FAIL parity_side_pulses: got ferr=%0d orphan=%0d expected 0 0", fcnt_b, orphan_perr_b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[3];
    exp_q = '{8'h12, 8'h34, 8'h56};
    clear_mon();
    send_bits(1'b0, frame_8n1(8'h12, 1'b1), 10);
    send_bits(1'b0, frame_8n1(8'h34, 1'b1), 10);
    send_bits(1'b0, frame_8n1(8'h56, 1'b1), 10);
    wait_clk(8);
    assert_cnt++; if (vcnt_a !== 3) begin fail_cnt++; $display("FAIL b2b_count: got %0d expected 3", vcnt_a); end
    for (int i = 0; i < 3; i++) begin
      assert_cnt++;
      if (q_a.size() <= i) begin
        fail_cnt++; $display("FAIL b2b_word%0d: got none expected %h", i, exp_q[i]);
      end else if (q_a[i] !== exp_q[i]) begin
        fail_cnt++; $display("FAIL b2b_word%0d: got %h expected %h", i, q_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    // start bit plus data bits 0..2 of 0xFF, then halfway into bit 3
    send_bits(1'b0, 16'h000F << 1, 4);
    rx_a = 1'b1;
    wait_clk(BIT_CLKS / 2);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(BIT_CLKS / 2 - 3 + 5 * BIT_CLKS);
    assert_cnt++; if (vcnt_a !== 0 || fcnt_a !== 0) begin fail_cnt++; $display("FAIL rstmid_no_pulse: got valid=%0d ferr=%0d expected 0 0", vcnt_a, fcnt_a); end
    assert_cnt++; if (data_a !== 8'h00) begin fail_cnt++; $display("FAIL rstmid_data: got %h expected 00", data_a); end
    assert_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
    send_bits(1'b0, frame_8n1(8'h81, 1'b1), 10);
    wait_clk(8);
    assert_cnt++; if (vcnt_a !== 1 || last_a !== 8'h81) begin fail_cnt++; $display("FAIL rstmid_next: got count=%0d data=%h expected 1 81", vcnt_a, last_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    assert_cnt++;
    if (glitch_a !== 0) begin
      fail_cnt++;
      $display("FAIL data_hold: got %0d unannounced data changes expected 0", glitch_a);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
